logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 99 +++++++++
 tb/tb_logic_unit_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with an optional accumulator feeding operand A, and a
// DEPTH-entry FIFO buffering results between the input and output handshakes.
module logic_unit_pipe #(
    parameter int BIT_LEN = 8,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BIT_LEN-1:0]       a,
    input  logic [BIT_LEN-1:0]       b,
    input  logic [2:0]               op,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_LEN-1:0]       c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Handshake: a side transfers on a rising edge where its valid and ready are
    // both high; valid never waits on ready, and ready is withheld while rst=1.
    logic                push;
    logic                pop;
    logic [BIT_LEN-1:0]  a_sel;
    logic [BIT_LEN-1:0]  result;
    logic [BIT_LEN-1:0]  acc_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [BIT_LEN-1:0]  mem [DEPTH];

    // A full buffer still accepts when the head leaves on the same edge.
    assign out_valid = (level != '0);
    assign in_ready  = !rst && ((level != FULL_LVL) || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign c         = mem[rd_ptr];

    // A clear on the same edge as an accumulate means the chain restarts from 0.
    always_comb begin
        a_sel = a;
        if (acc_en) begin
            a_sel = acc_clr ? '0 : acc_q;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = a_sel & b;
            3'b001:  result = a_sel | b;
            3'b010:  result = ~(a_sel & b);
            3'b011:  result = ~(a_sel | b);
            3'b100:  result = a_sel ^ b;
            3'b101:  result = ~(a_sel ^ b);
            3'b110:  result = ~a_sel;
            default: result = b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            acc_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push && acc_en) begin
                acc_q <= result;
            end else if (acc_clr) begin
                acc_q <= '0;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe against a queue-based
// reference model of the result buffer and accumulator.
module tb_logic_unit_pipe;

    localparam int BIT_LEN = 8;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] a;
    logic [BIT_LEN-1:0] b;
    logic [2:0]         op;
    logic               acc_en;
    logic               acc_clr;
    logic               out_valid;
    logic               out_ready;
    logic [BIT_LEN-1:0] c;
    logic [1:0]         level;

    int vectors     = 0;
    int miscompares = 0;

    logic [BIT_LEN-1:0] exp_q[$];
    logic [BIT_LEN-1:0] acc_m;

    logic_unit_pipe #(.BIT_LEN(BIT_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BIT_LEN-1:0] ref_op(input logic [2:0] o,
                                                  input logic [BIT_LEN-1:0] x,
                                                  input logic [BIT_LEN-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return y;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".level"}, 32'(level), 32'(exp_q.size()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, ".c"}, 32'(c), 32'(exp_q[0]));
    endtask

    // Applies one cycle of inputs, predicts the transfers, and checks after the edge.
    task automatic step(input string tag, input logic v, input logic [7:0] ai,
                        input logic [7:0] bi, input logic [2:0] oi, input logic ae,
                        input logic ac, input logic orr);
        logic               rdy_m, do_push, do_pop;
        logic [BIT_LEN-1:0] opa, res;
        in_valid = v; a = ai; b = bi; op = oi; acc_en = ae; acc_clr = ac; out_ready = orr;
        #1;
        rdy_m   = (exp_q.size() < DEPTH) || orr;
        do_push = v && rdy_m;
        do_pop  = orr && (exp_q.size() != 0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy_m));
        opa = ae ? (ac ? '0 : acc_m) : ai;
        res = ref_op(oi, opa, bi);
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(res);
        if (do_push && ae) acc_m = res;
        else if (ac) acc_m = '0;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; a = 0; b = 0; op = 0; acc_en = 0; acc_clr = 0; out_ready = 0;
        acc_m = '0;
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        // OR through an empty buffer with the consumer ready.
        step("or_push", 1, 8'hF0, 8'h0F, 3'b001, 0, 0, 1);
        check("or_c", 32'(c), 32'hFF);
        step("or_drain", 0, 8'h00, 8'h00, 3'b000, 0, 0, 1);

        // Fill, stall the third push, then release with simultaneous pop/push.
        step("fill0", 1, 8'hAA, 8'h55, 3'b000, 0, 0, 0);
        step("fill1", 1, 8'hAA, 8'h55, 3'b100, 0, 0, 0);
        check("full_level", 32'(level), 32'd2);
        step("held", 1, 8'hAA, 8'h55, 3'b010, 0, 0, 0);
        step("popush", 1, 8'hAA, 8'h55, 3'b010, 0, 0, 1);
        check("popush_level", 32'(level), 32'd2);
        step("drain0", 0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
        step("drain1", 0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
        step("drain2", 0, 8'h00, 8'h00, 3'b000, 0, 0, 1);

        // Accumulator chain.
        step("acc_clr", 0, 8'h00, 8'h00, 3'b000, 0, 1, 1);
        step("acc1", 1, 8'h99, 8'h01, 3'b001, 1, 0, 1);
        check("acc1_c", 32'(c), 32'h01);
        step("acc2", 1, 8'h99, 8'h02, 3'b001, 1, 0, 1);
        check("acc2_c", 32'(c), 32'h03);
        step("acc4", 1, 8'h99, 8'h04, 3'b001, 1, 0, 1);
        check("acc4_c", 32'(c), 32'h07);
        step("acc_clr_en", 1, 8'h99, 8'h10, 3'b001, 1, 1, 1);
        check("acc_clr_en_c", 32'(c), 32'h10);
        step("acc_drain", 0, 8'h00, 8'h00, 3'b000, 0, 0, 1);

        // Asynchronous reset with a full buffer and accumulator at 07.
        step("pre_clr", 0, 8'h00, 8'h00, 3'b000, 0, 1, 0);
        step("pre_a", 1, 8'h00, 8'h03, 3'b001, 1, 0, 0);
        step("pre_b", 1, 8'h00, 8'h07, 3'b001, 1, 0, 0);
        check("pre_level", 32'(level), 32'd2);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        acc_m = '0;
        check("arst.in_ready", 32'(in_ready), 32'd0);
        check_outputs("arst");
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("arst_rel");
        step("post_acc", 1, 8'hFF, 8'h00, 3'b001, 1, 0, 1);
        check("post_acc_c", 32'(c), 32'h00);

        step("not", 1, 8'h3C, 8'h00, 3'b110, 0, 0, 1);
        check("not_c", 32'(c), 32'hC3);
        step("passb", 1, 8'h00, 8'h5A, 3'b111, 0, 0, 1);
        check("passb_c", 32'(c), 32'h5A);
        step("nor", 1, 8'h00, 8'h00, 3'b011, 0, 0, 1);
        check("nor_c", 32'(c), 32'hFF);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
